// File: rtl/vga_plot_scheduler.sv
// Arbitrates two pixel requesters and a clear-screen fill onto one Avalon-MM VGA write port.
// Latency: pixel write 1 cycle after handshake; m_waitrequest holds the write and data; readies stay low until the write ends.
module vga_plot_scheduler #(
   parameter int XMAX = 160,
   parameter int YMAX = 120
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_x,
   input  logic [6:0]  req0_y,
   input  logic [7:0]  req0_colour,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_x,
   input  logic [6:0]  req1_y,
   input  logic [7:0]  req1_colour,
   output logic        req1_ready,
   input  logic        clear_start,
   input  logic [7:0]  clear_colour,
   output logic        clear_busy,
   output logic        clear_done,
   output logic [15:0] drop_count,
   output logic [3:0]  m_address,
   output logic        m_write,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest
);

   typedef struct packed {
      logic       pad;
      logic [6:0] y;
      logic [7:0] x;
      logic [7:0] rsvd;
      logic [7:0] colour;
   } pix_t;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

   localparam logic [8:0] XLIM  = 9'(XMAX);
   localparam logic [7:0] YLIM  = 8'(YMAX);
   localparam logic [7:0] XLAST = 8'(XMAX - 1);
   localparam logic [6:0] YLAST = 7'(YMAX - 1);

   state_t      state_q, state_d;
   logic        last_grant_q;
   pix_t        wdata_q;
   pix_t        req_pix;
   logic [15:0] drop_q;
   logic        done_q;
   logic        grant0, grant1;
   logic        in_range;
   logic        clear_last;

   assign req_pix    = grant1 ? {1'b0, req1_y, req1_x, 8'h00, req1_colour}
                              : {1'b0, req0_y, req0_x, 8'h00, req0_colour};
   assign in_range   = ({1'b0, req_pix.x} < XLIM) && ({1'b0, req_pix.y} < YLIM);
   assign clear_last = (wdata_q.x == XLAST) && (wdata_q.y == YLAST);

   always_comb begin
      state_d = state_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clear_start) begin
               state_d = S_CLEAR;
            end else begin
               // last_grant_q == 1 means requester 1 was served last, so 0 wins a tie
               grant0 = req0_valid && (!req1_valid || last_grant_q);
               grant1 = req1_valid && !grant0;
               if ((grant0 || grant1) && in_range) state_d = S_WRITE;
            end
         end
         S_WRITE: if (!m_waitrequest) state_d = S_IDLE;
         S_CLEAR: if (!m_waitrequest && clear_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         wdata_q      <= '0;
         drop_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (clear_start) begin
                  wdata_q <= {1'b0, 7'd0, 8'd0, 8'h00, clear_colour};
               end else if (grant0 || grant1) begin
                  last_grant_q <= grant1;
                  if (in_range)
                     wdata_q <= req_pix;
                  else if (drop_q != 16'hFFFF)
                     drop_q <= drop_q + 16'd1;
               end
            end
            S_CLEAR: begin
               // wdata_q doubles as the raster cursor; it only moves on a completed write
               if (!m_waitrequest) begin
                  if (wdata_q.x == XLAST) begin
                     wdata_q.x <= 8'd0;
                     if (wdata_q.y == YLAST) done_q <= 1'b1;
                     else                    wdata_q.y <= wdata_q.y + 7'd1;
                  end else begin
                     wdata_q.x <= wdata_q.x + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign req0_ready  = grant0;
   assign req1_ready  = grant1;
   assign clear_busy  = (state_q == S_CLEAR);
   assign clear_done  = done_q;
   assign drop_count  = drop_q;
   assign m_address   = 4'd0;
   assign m_write     = (state_q == S_WRITE) || (state_q == S_CLEAR);
   assign m_writedata = wdata_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Directed bench for vga_plot_scheduler: pixel path, round-robin, stalls, drops, clear and async reset.
module tb_vga_plot_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_valid, req1_valid;
   logic [7:0]  req0_x, req1_x, req0_colour, req1_colour;
   logic [6:0]  req0_y, req1_y;
   logic        req0_ready, req1_ready;
   logic        clear_start;
   logic [7:0]  clear_colour;
   logic        clear_busy, clear_done;
   logic [15:0] drop_count;
   logic [3:0]  m_address;
   logic        m_write;
   logic [31:0] m_writedata;
   logic        m_waitrequest;

   int errors = 0;
   int checks = 0;

   vga_plot_scheduler #(.XMAX(160), .YMAX(120)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
      .req0_colour(req0_colour), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
      .req1_colour(req1_colour), .req1_ready(req1_ready),
      .clear_start(clear_start), .clear_colour(clear_colour),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .drop_count(drop_count), .m_address(m_address), .m_write(m_write),
      .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   int n, st, bad_data, bad_wr, bad_rdy, bad_done, bad_busy, bad_mw;
   logic wt;
   logic [31:0] exp_d;

   initial begin
      reset_n = 1'b0;
      req0_valid = 0; req0_x = 0; req0_y = 0; req0_colour = 0;
      req1_valid = 0; req1_x = 0; req1_y = 0; req1_colour = 0;
      clear_start = 0; clear_colour = 0; m_waitrequest = 0;
      #1;
      chk("rst_r0", req0_ready, 0);
      chk("rst_r1", req1_ready, 0);
      chk("rst_mw", m_write, 0);
      chk("rst_wd", m_writedata, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_addr", m_address, 0);
      @(negedge clk); reset_n = 1'b1;

      // single pixel from requester 0
      @(negedge clk);
      req0_valid = 1; req0_x = 5; req0_y = 7; req0_colour = 8'hAA;
      #1;
      chk("p0_ready", req0_ready, 1);
      chk("p0_r1", req1_ready, 0);
      chk("p0_nowrite", m_write, 0);
      @(negedge clk); req0_valid = 0; #1;
      chk("p0_write", m_write, 1);
      chk("p0_data", m_writedata, 32'h0705_00AA);
      chk("p0_addr", m_address, 0);
      chk("p0_rdy_low", req0_ready, 0);
      @(negedge clk); #1;
      chk("p0_end", m_write, 0);

      // single pixel from requester 1
      req1_valid = 1; req1_x = 10; req1_y = 20; req1_colour = 8'h55;
      #1;
      chk("p1_ready", req1_ready, 1);
      chk("p1_r0", req0_ready, 0);
      @(negedge clk); req1_valid = 0; #1;
      chk("p1_write", m_write, 1);
      chk("p1_data", m_writedata, 32'h140A_0055);
      @(negedge clk);

      // round-robin with both held valid
      req0_valid = 1; req0_x = 1; req0_y = 2; req0_colour = 8'h11;
      req1_valid = 1; req1_x = 3; req1_y = 4; req1_colour = 8'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_r0", req0_ready, (i % 2 == 0));
         chk("rr_r1", req1_ready, (i % 2 == 1));
         @(negedge clk); #1;
         chk("rr_write", m_write, 1);
         chk("rr_data", m_writedata, (i % 2 == 0) ? 32'h0201_0011 : 32'h0403_0022);
         chk("rr_nordy", req0_ready | req1_ready, 0);
         if (i == 3) begin req0_valid = 0; req1_valid = 0; end
         @(negedge clk);
      end

      // backpressure: three stall cycles
      req0_valid = 1; req0_x = 9; req0_y = 9; req0_colour = 8'h77;
      #1;
      chk("bp_ready", req0_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         m_waitrequest = (i < 3);
         #1;
         chk("bp_write", m_write, 1);
         chk("bp_data", m_writedata, 32'h0909_0077);
         chk("bp_rdy_low", req0_ready, 0);
      end
      @(negedge clk); #1;
      chk("bp_next_ready", req0_ready, 1);
      chk("bp_idle", m_write, 0);
      req0_valid = 0;

      // out-of-range drops, then the corner pixel that is still in range
      @(negedge clk);
      req1_valid = 1; req1_x = 160; req1_y = 3; req1_colour = 8'h01;
      #1;
      chk("dr_ready", req1_ready, 1);
      chk("dr_cnt0", drop_count, 0);
      @(negedge clk);
      req1_valid = 0;
      req0_valid = 1; req0_x = 0; req0_y = 120; req0_colour = 8'h02;
      #1;
      chk("dr_nowrite", m_write, 0);
      chk("dr_cnt1", drop_count, 1);
      chk("dr_next", req0_ready, 1);
      @(negedge clk);
      req0_x = 159; req0_y = 119; req0_colour = 8'hC3;
      #1;
      chk("dr_cnt2", drop_count, 2);
      chk("dr_nowrite2", m_write, 0);
      chk("edge_ready", req0_ready, 1);
      @(negedge clk); req0_valid = 0; #1;
      chk("edge_write", m_write, 1);
      chk("edge_data", m_writedata, 32'h779F_00C3);
      @(negedge clk);

      // full clear while requester 0 waits
      req0_valid = 1; req0_x = 2; req0_y = 3; req0_colour = 8'h44;
      clear_start = 1; clear_colour = 8'h3C;
      #1;
      chk("cl_r0", req0_ready, 0);
      chk("cl_busy0", clear_busy, 0);
      @(negedge clk);
      clear_start = 0; clear_colour = 8'h00;
      n = 0; st = 0; bad_data = 0; bad_wr = 0; bad_rdy = 0; bad_done = 0; bad_busy = 0;
      for (int c = 0; c < 20000 && n < 19200; c++) begin
         if (c > 0) @(negedge clk);
         wt = (n == 500 && st < 2);
         if (wt) st++;
         m_waitrequest = wt;
         #1;
         exp_d = {1'b0, 7'(n / 160), 8'(n % 160), 8'h00, 8'h3C};
         if (c == 0)     chk("cl_first", m_writedata, 32'h0000_003C);
         if (n == 19199) chk("cl_last", m_writedata, 32'h779F_003C);
         if (m_writedata !== exp_d) bad_data++;
         if (m_write !== 1'b1)      bad_wr++;
         if (req0_ready !== 1'b0)   bad_rdy++;
         if (clear_done !== 1'b0)   bad_done++;
         if (clear_busy !== 1'b1)   bad_busy++;
         if (!wt) n++;
      end
      m_waitrequest = 0;
      chk("cl_count", n, 19200);
      chk("cl_order", bad_data, 0);
      chk("cl_mw_high", bad_wr, 0);
      chk("cl_r0_low", bad_rdy, 0);
      chk("cl_no_early_done", bad_done, 0);
      chk("cl_busy", bad_busy, 0);
      @(negedge clk); #1;
      chk("cl_done", clear_done, 1);
      chk("cl_busy_end", clear_busy, 0);
      chk("cl_mw_end", m_write, 0);
      chk("cl_r0_after", req0_ready, 1);
      @(negedge clk); req0_valid = 0; #1;
      chk("cl_done_pulse", clear_done, 0);
      chk("cl_px_write", m_write, 1);
      chk("cl_px_data", m_writedata, 32'h0302_0044);
      @(negedge clk);

      // drop counter saturation
      req1_valid = 1; req1_x = 200; req1_y = 0; req1_colour = 8'h00;
      bad_mw = 0;
      for (int i = 0; i < 65533; i++) begin
         @(negedge clk);
         if (m_write !== 1'b0) bad_mw++;
      end
      #1;
      chk("sat_ffff", drop_count, 16'hFFFF);
      @(negedge clk); @(negedge clk); #1;
      chk("sat_hold", drop_count, 16'hFFFF);
      chk("sat_nowrite", bad_mw, 0);
      req1_valid = 0;

      // async reset in the middle of a clear
      @(negedge clk);
      clear_start = 1; clear_colour = 8'h81;
      @(negedge clk);
      clear_start = 0;
      for (int i = 0; i < 100; i++) @(negedge clk);
      #1;
      chk("rs_pos", m_writedata, 32'h0064_0081);
      reset_n = 1'b0;
      #1;
      chk("rs_mw", m_write, 0);
      chk("rs_busy", clear_busy, 0);
      chk("rs_drop", drop_count, 0);
      chk("rs_done", clear_done, 0);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk); #1;
      chk("rs_idle_mw", m_write, 0);
      chk("rs_idle_busy", clear_busy, 0);
      chk("rs_no_done", clear_done, 0);
      clear_start = 1; clear_colour = 8'h5A;
      @(negedge clk); clear_start = 0; #1;
      chk("rs_restart_mw", m_write, 1);
      chk("rs_restart_data", m_writedata, 32'h0000_005A);
      chk("rs_restart_busy", clear_busy, 1);
      @(negedge clk); #1;
      chk("rs_second_px", m_writedata, 32'h0001_005A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
